// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues in-order requests to
// instruction memory, buffers responses, and hands {pc, instr} pairs to decode
// over valid/ready. A redirect flushes the buffer and marks every request
// still outstanding as stale so its response is discarded on arrival.
module fetch_unit #(
  parameter int             N        = 64,
  parameter int             INSTR_W  = 32,
  parameter int             MAX_OUT  = 2,
  parameter logic [N-1:0]   RESET_PC = {N{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               br_taken,
  input  logic [N-1:0]       br_target,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [N-1:0]       imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [N-1:0]       if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  localparam int            PW       = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int            CW       = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUT);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUT - 1);

  // architectural and queue state
  logic [N-1:0]       pc_r;
  logic [N-1:0]       aq_mem_r [MAX_OUT];
  logic [PW-1:0]      aq_wr_ptr_r;
  logic [PW-1:0]      aq_rd_ptr_r;
  logic [N-1:0]       buf_pc_r [MAX_OUT];
  logic [INSTR_W-1:0] buf_instr_r [MAX_OUT];
  logic [PW-1:0]      buf_wr_ptr_r;
  logic [PW-1:0]      buf_rd_ptr_r;
  logic [CW-1:0]      buf_count_r;
  logic [CW-1:0]      inflight_r;
  logic [CW-1:0]      drop_r;

  // per-cycle control
  logic [CW:0]        credit_s;
  logic               req_valid_s;
  logic               fire_s;
  logic               rsp_ok_s;
  logic               rsp_keep_s;
  logic               pop_s;
  logic [CW-1:0]      inflight_nxt_s;
  logic [CW-1:0]      drop_nxt_s;
  logic [CW-1:0]      buf_count_nxt_s;
  logic [N-1:0]       br_pc_s;

  // The low target bits are forced to zero, so they are intentionally unused.
  logic               unused_br_lsb_s;
  assign unused_br_lsb_s = ^br_target[1:0];

  // Ring-pointer advance that wraps at MAX_OUT.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == LAST_PTR) begin
      r = {PW{1'b0}};
    end else begin
      r = p + PW'(1);
    end
    return r;
  endfunction

  // Credit check, handshake qualification and next-value arithmetic for counters.
  always_comb begin
    credit_s    = {1'b0, inflight_r} + {1'b0, buf_count_r};
    req_valid_s = 1'b0;
    if (!reset || br_taken) begin
      req_valid_s = 1'b0;
    end else if (credit_s < {1'b0, MAX_CNT}) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
    fire_s          = req_valid_s & imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_ok_s        = imem_rsp_valid & (inflight_r != ZERO_CNT);
    rsp_keep_s      = rsp_ok_s & (drop_r == ZERO_CNT) & ~br_taken;
    pop_s           = (buf_count_r != ZERO_CNT) & if_ready & ~br_taken;
    inflight_nxt_s  = inflight_r + CW'(fire_s) - CW'(rsp_ok_s);
    buf_count_nxt_s = buf_count_r + CW'(rsp_keep_s) - CW'(pop_s);
    br_pc_s         = {br_target[N-1:2], 2'b00};
    drop_nxt_s      = drop_r;
    if (br_taken) begin
      // Everything still outstanding after this cycle's response is stale.
      drop_nxt_s = inflight_r - CW'(rsp_ok_s);
    end else if (rsp_ok_s && (drop_r != ZERO_CNT)) begin
      drop_nxt_s = drop_r - CW'(1);
    end else begin
      drop_nxt_s = drop_r;
    end
  end

  // PC register: redirect wins over sequential advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_PC;
    end else if (br_taken) begin
      pc_r <= br_pc_s;
    end else if (fire_s) begin
      pc_r <= pc_r + N'(4);
    end
  end

  // In-flight and stale-response counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_r <= ZERO_CNT;
      drop_r     <= ZERO_CNT;
    end else begin
      inflight_r <= inflight_nxt_s;
      drop_r     <= drop_nxt_s;
    end
  end

  // Address queue: remembers the PC of each outstanding request, in order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aq_wr_ptr_r <= {PW{1'b0}};
      aq_rd_ptr_r <= {PW{1'b0}};
      for (int i = 0; i < MAX_OUT; i++) begin
        aq_mem_r[i] <= {N{1'b0}};
      end
    end else begin
      if (fire_s) begin
        aq_mem_r[aq_wr_ptr_r] <= pc_r;
        aq_wr_ptr_r           <= ptr_inc(aq_wr_ptr_r);
      end
      if (rsp_ok_s) begin
        aq_rd_ptr_r <= ptr_inc(aq_rd_ptr_r);
      end
    end
  end

  // Response buffer: a flush keeps the head pointer so the outputs hold their last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_wr_ptr_r <= {PW{1'b0}};
      buf_rd_ptr_r <= {PW{1'b0}};
      buf_count_r  <= ZERO_CNT;
      for (int i = 0; i < MAX_OUT; i++) begin
        buf_pc_r[i]    <= {N{1'b0}};
        buf_instr_r[i] <= {INSTR_W{1'b0}};
      end
    end else if (br_taken) begin
      buf_wr_ptr_r <= buf_rd_ptr_r;
      buf_count_r  <= ZERO_CNT;
    end else begin
      if (rsp_keep_s) begin
        buf_pc_r[buf_wr_ptr_r]    <= aq_mem_r[aq_rd_ptr_r];
        buf_instr_r[buf_wr_ptr_r] <= imem_rsp_data;
        buf_wr_ptr_r              <= ptr_inc(buf_wr_ptr_r);
      end
      if (pop_s) begin
        buf_rd_ptr_r <= ptr_inc(buf_rd_ptr_r);
      end
      buf_count_r <= buf_count_nxt_s;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_r;
  assign if_valid       = (buf_count_r != ZERO_CNT);
  assign if_pc          = buf_pc_r[buf_rd_ptr_r];
  assign if_instr       = buf_instr_r[buf_rd_ptr_r];

endmodule
